boreal_watchdog_mc: RTL and testbench

BOREAL_WATCHDOG_MC -- requirements
Module: boreal_watchdog_mc

---
 rtl/boreal_watchdog_mc_if.sv | 36 +++
 rtl/boreal_watchdog_mc.sv | 206 ++++++++++++++++++++
 tb/tb_boreal_watchdog_mc.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/boreal_watchdog_mc_if.sv
// Watchdog bundle: per-channel kick/arm in,
// warn/fault status and fault statistics out.
interface boreal_watchdog_mc_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] kick;
  logic [NUM_CH-1:0] enable;
  logic              clear;
  logic [NUM_CH-1:0] warn;
  logic [NUM_CH-1:0] fault;
  logic [NUM_CH-1:0] fault_pulse;
  logic              any_fault;
  logic [7:0]        fault_count;

  modport master (
    output kick,
    output enable,
    output clear,
    input  warn,
    input  fault,
    input  fault_pulse,
    input  any_fault,
    input  fault_count
  );

  modport slave (
    input  kick,
    input  enable,
    input  clear,
    output warn,
    output fault,
    output fault_pulse,
    output any_fault,
    output fault_count
  );
endinterface

// File: rtl/boreal_watchdog_mc.sv
// Multi-channel watchdog with warn/fault/recover FSM per channel.
// Optional early-kick window fault: define BOREAL_WDT_WINDOW_EN.
module boreal_watchdog_mc #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 23,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int WARN_CYCLES    = 4_000_000,
  parameter int RECOVER_KICKS  = 4,
  parameter int MIN_INTERVAL   = 1000
) (
  input  logic clk,
  input  logic rst,
  boreal_watchdog_mc_if.slave wd
);

  localparam int RC_W = $clog2(RECOVER_KICKS + 1);
  localparam logic [CNT_W-1:0] TO =
    CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WN =
    CNT_W'(WARN_CYCLES);
  localparam logic [RC_W-1:0] RK =
    RC_W'(RECOVER_KICKS);

  if (NUM_CH < 1 || NUM_CH > 16 ||
      WARN_CYCLES <= 0 ||
      WARN_CYCLES >= TIMEOUT_CYCLES ||
      longint'(TIMEOUT_CYCLES) >=
        (longint'(1) << CNT_W) ||
      RECOVER_KICKS < 1 ||
      MIN_INTERVAL < 0) begin : g_bad_cfg
    $error("boreal_watchdog_mc: bad parameters");
  end

  typedef enum logic [2:0] {
    S_DIS,
    S_RUN,
    S_WARN,
    S_FAULT,
    S_REC
  } state_e;

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [CNT_W-1:0] cnt_inc [NUM_CH];
  logic [RC_W-1:0]  rc_q    [NUM_CH];
  logic [RC_W-1:0]  rc_d    [NUM_CH];

  logic [NUM_CH-1:0] early;
  logic [NUM_CH-1:0] warn_q, warn_d;
  logic [NUM_CH-1:0] fault_q, fault_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic              any_q;
  logic [7:0]        fcnt_q, fcnt_d;
  logic [8:0]        fsum;

`ifdef BOREAL_WDT_WINDOW_EN
  localparam logic [CNT_W-1:0] MI =
    CNT_W'(MIN_INTERVAL);

  always_comb begin
    early = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      early[i] = cnt_q[i] < MI;
    end
  end
`else
  assign early = '0;
`endif

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rc_d[i]    = rc_q[i];
      pulse_d[i] = 1'b0;
      cnt_inc[i] = cnt_q[i] + 1'b1;

      if (!wd.enable[i]) begin
        state_d[i] = S_DIS;
        cnt_d[i]   = '0;
        rc_d[i]    = '0;
      end else begin
        unique case (state_q[i])
          S_DIS: begin
            state_d[i] = S_RUN;
            cnt_d[i]   = '0;
            rc_d[i]    = '0;
          end
          S_RUN, S_WARN: begin
            if (wd.kick[i] && early[i]) begin
              state_d[i] = S_FAULT;
              cnt_d[i]   = TO;
              pulse_d[i] = 1'b1;
            end else if (wd.kick[i]) begin
              state_d[i] = S_RUN;
              cnt_d[i]   = '0;
            end else if (cnt_inc[i] >= TO) begin
              state_d[i] = S_FAULT;
              cnt_d[i]   = TO;
              pulse_d[i] = 1'b1;
            end else begin
              cnt_d[i]   = cnt_inc[i];
              state_d[i] = (cnt_inc[i] >= WN) ?
                           S_WARN : S_RUN;
            end
          end
          S_FAULT: begin
            if (wd.clear) begin
              state_d[i] = S_RUN;
              cnt_d[i]   = '0;
              rc_d[i]    = '0;
            end else if (wd.kick[i]) begin
              cnt_d[i] = '0;
              if (RK == RC_W'(1)) begin
                state_d[i] = S_RUN;
                rc_d[i]    = '0;
              end else begin
                state_d[i] = S_REC;
                rc_d[i]    = RC_W'(1);
              end
            end
          end
          S_REC: begin
            if (wd.clear) begin
              state_d[i] = S_RUN;
              cnt_d[i]   = '0;
              rc_d[i]    = '0;
            end else if (wd.kick[i] && early[i]) begin
              state_d[i] = S_FAULT;
              cnt_d[i]   = TO;
              rc_d[i]    = '0;
            end else if (wd.kick[i]) begin
              cnt_d[i] = '0;
              if (rc_q[i] + 1'b1 == RK) begin
                state_d[i] = S_RUN;
                rc_d[i]    = '0;
              end else begin
                rc_d[i] = rc_q[i] + 1'b1;
              end
            end else if (cnt_inc[i] >= TO) begin
              // recovery lapsed: silent return to fault
              state_d[i] = S_FAULT;
              cnt_d[i]   = TO;
              rc_d[i]    = '0;
            end else begin
              cnt_d[i] = cnt_inc[i];
            end
          end
          default: begin
            state_d[i] = S_DIS;
            cnt_d[i]   = '0;
            rc_d[i]    = '0;
          end
        endcase
      end

      warn_d[i]  = state_d[i] == S_WARN;
      fault_d[i] = (state_d[i] == S_FAULT) ||
                   (state_d[i] == S_REC);
    end
  end

  // clear restarts the tally; same-cycle entries still count
  always_comb begin
    fsum = wd.clear ? 9'd0 : {1'b0, fcnt_q};
    for (int i = 0; i < NUM_CH; i++) begin
      fsum = fsum + 9'(pulse_d[i]);
    end
    fcnt_d = fsum[8] ? 8'hFF : fsum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_DIS;
        cnt_q[i]   <= '0;
        rc_q[i]    <= '0;
      end
      warn_q  <= '0;
      fault_q <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rc_q[i]    <= rc_d[i];
      end
      warn_q  <= warn_d;
      fault_q <= fault_d;
      pulse_q <= pulse_d;
      any_q   <= |fault_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign wd.warn        = warn_q;
  assign wd.fault       = fault_q;
  assign wd.fault_pulse = pulse_q;
  assign wd.any_fault   = any_q;
  assign wd.fault_count = fcnt_q;

endmodule

// File: tb/tb_boreal_watchdog_mc.sv
// Scoreboard bench for boreal_watchdog_mc:
// TIMEOUT=16, WARN=12, RECOVER_KICKS=3, MIN_INTERVAL=4.
module tb_boreal_watchdog_mc;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  boreal_watchdog_mc_if #(.NUM_CH(4)) wd ();

  boreal_watchdog_mc #(
    .NUM_CH        (4),
    .CNT_W         (8),
    .TIMEOUT_CYCLES(16),
    .WARN_CYCLES   (12),
    .RECOVER_KICKS (3),
    .MIN_INTERVAL  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wd (wd)
  );

  typedef struct {
    logic [3:0] w;
    logic [3:0] f;
    logic [3:0] p;
    logic       a;
    logic [7:0] n;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  exp_t m;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cyc(
    input logic [3:0] k,
    input logic [3:0] en,
    input logic       c,
    input logic       r,
    input logic [3:0] w,
    input logic [3:0] f,
    input logic [3:0] p,
    input logic [7:0] n,
    input string      tag
  );
    exp_t e;
    @(negedge clk);
    wd.kick   = k;
    wd.enable = en;
    wd.clear  = c;
    rst       = r;
    e.w   = w;
    e.f   = f;
    e.p   = p;
    e.a   = |f;
    e.n   = n;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  // ch bits in RUN with counter 0 time out after 16 edges;
  // other enabled channels are kicked every cycle
  task automatic run_to_fault(
    input logic [3:0] en,
    input logic [3:0] ch,
    input logic [7:0] nb,
    input logic [7:0] na
  );
    logic [3:0] k;
    k = en & ~ch;
    for (int i = 1; i <= 11; i++)
      cyc(k, en, 0, 0, 0, 0, 0, nb, "count");
    for (int i = 12; i <= 15; i++)
      cyc(k, en, 0, 0, ch, 0, 0, nb, "warn");
    cyc(k, en, 0, 0, 0, ch, ch, na, "fault");
  endtask

  task automatic kick_out(
    input logic [3:0] k,
    input logic [3:0] en,
    input logic [3:0] f,
    input logic [7:0] n
  );
    cyc(k, en, 0, 0, 0, f, 0, n, "rkick1");
    cyc(k, en, 0, 0, 0, f, 0, n, "rkick2");
    cyc(k, en, 0, 0, 0, 0, 0, n, "rkick3");
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        m = sbq.pop_front();
        n_cmp++;
        if ({wd.warn, wd.fault, wd.fault_pulse,
             wd.any_fault, wd.fault_count} !==
            {m.w, m.f, m.p, m.a, m.n}) begin
          n_bad++;
          $display(
            "FAIL %s: got w=%b f=%b p=%b a=%b n=%0d exp w=%b f=%b p=%b a=%b n=%0d",
            m.tag, wd.warn, wd.fault,
            wd.fault_pulse, wd.any_fault,
            wd.fault_count, m.w, m.f, m.p,
            m.a, m.n);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    wd.kick   = '0;
    wd.enable = '0;
    wd.clear  = 1'b0;

    // single-channel timeout
    cyc(0, 0, 0, 1, 0, 0, 0, 0, "reset");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "en0");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, "kick0");
    run_to_fault(4'b0001, 4'b0001, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 0, 0, 1, 0, 1, "fhold");

    // recovery: kicks every 8 cycles
    cyc(1, 1, 0, 0, 0, 1, 0, 1, "rec_k1");
    for (int i = 0; i < 7; i++)
      cyc(0, 1, 0, 0, 0, 1, 0, 1, "rec_gap1");
    cyc(1, 1, 0, 0, 0, 1, 0, 1, "rec_k2");
    for (int i = 0; i < 7; i++)
      cyc(0, 1, 0, 0, 0, 1, 0, 1, "rec_gap2");
    cyc(1, 1, 0, 0, 0, 0, 0, 1, "rec_k3");
    run_to_fault(4'b0001, 4'b0001, 1, 2);

    // recovery lapses after the 2nd kick
    cyc(1, 1, 0, 0, 0, 1, 0, 2, "lap_k1");
    for (int i = 0; i < 7; i++)
      cyc(0, 1, 0, 0, 0, 1, 0, 2, "lap_gap");
    cyc(1, 1, 0, 0, 0, 1, 0, 2, "lap_k2");
    for (int i = 0; i < 16; i++)
      cyc(0, 1, 0, 0, 0, 1, 0, 2, "lap_idle");
    cyc(1, 1, 0, 0, 0, 1, 0, 2, "lap_rk1");
    cyc(1, 1, 0, 0, 0, 1, 0, 2, "lap_rk2");

    // reset while faulted, enable held
    cyc(0, 1, 0, 1, 0, 0, 0, 0, "rst_mid");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "rst_rel");
    run_to_fault(4'b0001, 4'b0001, 0, 1);

    // all channels together, up to saturation
    cyc(0, 4'hF, 0, 1, 0, 0, 0, 0, "rst_all");
    cyc(0, 4'hF, 0, 0, 0, 0, 0, 0, "en_all");
    run_to_fault(4'hF, 4'hF, 0, 4);
    for (int r = 1; r <= 62; r++) begin
      kick_out(4'hF, 4'hF, 4'hF, 8'(4 * r));
      run_to_fault(4'hF, 4'hF, 8'(4 * r),
                   8'(4 * r + 4));
    end
    kick_out(4'hF, 4'hF, 4'hF, 252);
    run_to_fault(4'hF, 4'b0001, 252, 253);
    kick_out(4'hF, 4'hF, 4'b0001, 253);
    run_to_fault(4'hF, 4'hF, 253, 255);
    kick_out(4'hF, 4'hF, 4'hF, 255);
    run_to_fault(4'hF, 4'hF, 255, 255);

    // clear beats kick; enable drop mid-warn
    cyc(4'b0010, 4'hF, 1, 0, 0, 0, 0, 0, "clear");
    for (int i = 1; i <= 11; i++)
      cyc(0, 4'hF, 0, 0, 0, 0, 0, 0, "cl_count");
    cyc(0, 4'hF, 0, 0, 4'hF, 0, 0, 0, "cl_warn");
    cyc(0, 4'hB, 0, 0, 4'hB, 0, 0, 0, "en2_drop");
    cyc(0, 4'hB, 0, 0, 4'hB, 0, 0, 0, "en2_off1");
    cyc(0, 4'hB, 0, 0, 4'hB, 0, 0, 0, "en2_off2");
    cyc(0, 4'hB, 0, 0, 0, 4'hB, 4'hB, 3, "fault3");
    cyc(0, 4'hB, 0, 0, 0, 4'hB, 0, 3, "plow3");

    // early kick
    cyc(0, 1, 0, 1, 0, 0, 0, 0, "rst_win");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "en_win");
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 0, 0, 0, 0, 0, 0, "win_idle");
    cyc(1, 1, 0, 0, 0, 0, 0, 0, "win_k0");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "win_gap");
`ifdef BOREAL_WDT_WINDOW_EN
    cyc(1, 1, 0, 0, 0, 1, 1, 1, "win_early");
    for (int i = 1; i <= 12; i++)
      cyc(0, 1, 0, 0, 0, 1, 0, 1, "win_hold");
`else
    cyc(1, 1, 0, 0, 0, 0, 0, 0, "win_early");
    for (int i = 1; i <= 11; i++)
      cyc(0, 1, 0, 0, 0, 0, 0, 0, "win_cnt");
    cyc(0, 1, 0, 0, 1, 0, 0, 0, "win_warn");
`endif

    repeat (2) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d required=0",
               sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
